// File: rtl/pipeline_stall_flush_ctrl.sv
// pipeline_stall_flush_ctrl
//
// Turns the hazard unit's requests (load-use stall, taken branch) and the
// data-memory busy signal into per-cycle enables and bubbles for the PC,
// IF/ID and ID/EX registers, plus a PC redirect. A branch that resolves
// while memory is busy is held and replayed as soon as the freeze ends.
// Saturating counters keep hazard statistics.
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   stall_req             load-use stall request (combinational)
//   flush_req             taken branch, one-cycle pulse
//   branch_target         redirect address qualified by flush_req
//   mem_busy              data memory not ready, freezes the whole pipeline
//   cnt_clr               synchronous clear of the statistics counters
//   pc_write, if_id_write, id_ex_write   register enables
//   if_id_flush, id_ex_flush             bubble insertion
//   pc_redirect, redirect_pc             PC mux select and address
//   state                 RUN=0, FLUSH=1, FREEZE=2
//   stall_count, flush_count, freeze_count   saturating statistics
module pipeline_stall_flush_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_req,
  input  logic                 flush_req,
  input  logic [XLEN-1:0]      branch_target,
  input  logic                 mem_busy,
  input  logic                 cnt_clr,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 id_ex_write,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 pc_redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [1:0]           state,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count,
  output logic [CNT_WIDTH-1:0] freeze_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    FREEZE = 2'd2
  } state_e;

  localparam int REM_W = 3;

  state_e               state_q, state_d;
  state_e               resume_q, resume_d;
  logic [REM_W-1:0]     remaining_q, remaining_d;
  logic                 pending_valid_q, pending_valid_d;
  logic [XLEN-1:0]      pending_pc_q, pending_pc_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
  logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;
  logic [CNT_WIDTH-1:0] freeze_count_q, freeze_count_d;

  logic   stall_inc, flush_inc, freeze_inc;
  logic   redirect_now;
  state_e eff_state;

  // While frozen, behave as the state we will resume into once memory frees up.
  assign eff_state    = (state_q == FREEZE) ? resume_q : state_q;
  assign redirect_now = flush_req | pending_valid_q;

  assign state        = state_q;
  assign stall_count  = stall_count_q;
  assign flush_count  = flush_count_q;
  assign freeze_count = freeze_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RUN;
      resume_q        <= RUN;
      remaining_q     <= '0;
      pending_valid_q <= 1'b0;
      pending_pc_q    <= '0;
      stall_count_q   <= '0;
      flush_count_q   <= '0;
      freeze_count_q  <= '0;
    end else begin
      state_q         <= state_d;
      resume_q        <= resume_d;
      remaining_q     <= remaining_d;
      pending_valid_q <= pending_valid_d;
      pending_pc_q    <= pending_pc_d;
      stall_count_q   <= stall_count_d;
      flush_count_q   <= flush_count_d;
      freeze_count_q  <= freeze_count_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    resume_d        = resume_q;
    remaining_d     = remaining_q;
    pending_valid_d = pending_valid_q;
    pending_pc_d    = pending_pc_q;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    freeze_inc      = 1'b0;

    if (mem_busy) begin
      // Remember where to go back to only on entry; remaining is left untouched.
      state_d    = FREEZE;
      freeze_inc = 1'b1;
      if (state_q != FREEZE) begin
        resume_d = state_q;
      end
      if (flush_req) begin
        pending_valid_d = 1'b1;
        pending_pc_d    = branch_target;
      end
    end else if (redirect_now) begin
      pending_valid_d = 1'b0;
      flush_inc       = 1'b1;
      resume_d        = RUN;
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        remaining_d = REM_W'(FLUSH_CYCLES - 1);
      end else begin
        state_d     = RUN;
        remaining_d = '0;
      end
    end else if (eff_state == FLUSH) begin
      resume_d    = RUN;
      remaining_d = remaining_q - 1'b1;
      state_d     = (remaining_q <= REM_W'(1)) ? RUN : FLUSH;
    end else begin
      state_d   = RUN;
      resume_d  = RUN;
      stall_inc = stall_req;
    end
  end

  // Saturating statistics; a clear wins over any increment in the same cycle.
  always_comb begin
    stall_count_d  = stall_count_q;
    flush_count_d  = flush_count_q;
    freeze_count_d = freeze_count_q;
    if (cnt_clr) begin
      stall_count_d  = '0;
      flush_count_d  = '0;
      freeze_count_d = '0;
    end else begin
      if (stall_inc && (stall_count_q != '1))   stall_count_d  = stall_count_q + 1'b1;
      if (flush_inc && (flush_count_q != '1))   flush_count_d  = flush_count_q + 1'b1;
      if (freeze_inc && (freeze_count_q != '1)) freeze_count_d = freeze_count_q + 1'b1;
    end
  end

  // Outputs are forced to the idle pattern while reset is held, regardless of inputs.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;

    if (!rst_n) begin
      pc_write = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
    end else if (redirect_now) begin
      pc_redirect = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      redirect_pc = flush_req ? branch_target : pending_pc_q;
    end else if (eff_state == FLUSH) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall_req) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_flush_ctrl.sv
// Directed bench for pipeline_stall_flush_ctrl with FLUSH_CYCLES=2, CNT_WIDTH=4.
module tb_pipeline_stall_flush_ctrl;

  localparam logic [5:0] C_IDLE   = 6'b111000;
  localparam logic [5:0] C_STALL  = 6'b001010;
  localparam logic [5:0] C_REDIR  = 6'b111111;
  localparam logic [5:0] C_BUBBLE = 6'b111110;
  localparam logic [5:0] C_FROZEN = 6'b000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_req, flush_req, mem_busy, cnt_clr;
  logic [31:0] branch_target;
  logic        pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, pc_redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  state;
  logic [3:0]  stall_count, flush_count, freeze_count;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic        busy;
    logic        clr;
    logic [5:0]  ctl;
    logic [31:0] rpc;
    logic [1:0]  st;
    logic [3:0]  sc;
    logic [3:0]  fc;
    logic [3:0]  zc;
  } vec_t;

  vec_t vecs[22];

  pipeline_stall_flush_ctrl #(
    .XLEN(32), .FLUSH_CYCLES(2), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_req(stall_req), .flush_req(flush_req), .branch_target(branch_target),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .state(state),
    .stall_count(stall_count), .flush_count(flush_count), .freeze_count(freeze_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic s, logic f, logic [31:0] t, logic b, logic c,
                              logic [5:0] ctl, logic [31:0] rpc, logic [1:0] st,
                              logic [3:0] sc, logic [3:0] fc, logic [3:0] zc);
    vec_t v;
    v.stall = s; v.flush = f; v.target = t; v.busy = b; v.clr = c;
    v.ctl = ctl; v.rpc = rpc; v.st = st; v.sc = sc; v.fc = fc; v.zc = zc;
    return v;
  endfunction

  function automatic logic [5:0] ctlNow();
    return {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, pc_redirect};
  endfunction

  task automatic applyStimulus(input logic s, input logic f, input logic [31:0] t,
                               input logic b, input logic c);
    stall_req     = s;
    flush_req     = f;
    branch_target = t;
    mem_busy      = b;
    cnt_clr       = c;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // stall flush target busy clr | ctl rpc state sc fc zc (state/counters seen before the edge)
    vecs[0]  = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd0, 4'd0, 4'd0);
    vecs[1]  = mk(1, 0, 32'h0,   0, 0, C_STALL,  32'h0,   2'd0, 4'd0, 4'd0, 4'd0);
    vecs[2]  = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd1, 4'd0, 4'd0);
    vecs[3]  = mk(0, 1, 32'h100, 0, 0, C_REDIR,  32'h100, 2'd0, 4'd1, 4'd0, 4'd0);
    vecs[4]  = mk(1, 0, 32'h0,   0, 0, C_BUBBLE, 32'h0,   2'd1, 4'd1, 4'd1, 4'd0);
    vecs[5]  = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd1, 4'd1, 4'd0);
    vecs[6]  = mk(1, 1, 32'h140, 0, 0, C_REDIR,  32'h140, 2'd0, 4'd1, 4'd1, 4'd0);
    vecs[7]  = mk(0, 1, 32'h180, 0, 0, C_REDIR,  32'h180, 2'd1, 4'd1, 4'd2, 4'd0);
    vecs[8]  = mk(0, 0, 32'h0,   0, 0, C_BUBBLE, 32'h0,   2'd1, 4'd1, 4'd3, 4'd0);
    vecs[9]  = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd1, 4'd3, 4'd0);
    vecs[10] = mk(0, 1, 32'h200, 1, 0, C_FROZEN, 32'h0,   2'd0, 4'd1, 4'd3, 4'd0);
    vecs[11] = mk(0, 0, 32'h300, 1, 0, C_FROZEN, 32'h0,   2'd2, 4'd1, 4'd3, 4'd1);
    vecs[12] = mk(1, 0, 32'h0,   1, 0, C_FROZEN, 32'h0,   2'd2, 4'd1, 4'd3, 4'd2);
    vecs[13] = mk(0, 0, 32'h0,   0, 0, C_REDIR,  32'h200, 2'd2, 4'd1, 4'd3, 4'd3);
    vecs[14] = mk(1, 0, 32'h0,   0, 0, C_BUBBLE, 32'h0,   2'd1, 4'd1, 4'd4, 4'd3);
    vecs[15] = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd1, 4'd4, 4'd3);
    vecs[16] = mk(0, 1, 32'h400, 0, 0, C_REDIR,  32'h400, 2'd0, 4'd1, 4'd4, 4'd3);
    vecs[17] = mk(0, 0, 32'h0,   1, 0, C_FROZEN, 32'h0,   2'd1, 4'd1, 4'd5, 4'd3);
    vecs[18] = mk(0, 0, 32'h0,   0, 0, C_BUBBLE, 32'h0,   2'd2, 4'd1, 4'd5, 4'd4);
    vecs[19] = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd1, 4'd5, 4'd4);
    vecs[20] = mk(1, 0, 32'h0,   0, 1, C_STALL,  32'h0,   2'd0, 4'd1, 4'd5, 4'd4);
    vecs[21] = mk(0, 0, 32'h0,   0, 0, C_IDLE,   32'h0,   2'd0, 4'd0, 4'd0, 4'd0);

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset ctl", 32'(ctlNow()), 32'(C_IDLE));
    checkOutput("reset state", 32'(state), 32'd0);
    checkOutput("reset counters", {20'h0, stall_count, flush_count, freeze_count}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].stall, vecs[i].flush, vecs[i].target, vecs[i].busy, vecs[i].clr);
      #1;
      checkOutput($sformatf("v%0d ctl", i), 32'(ctlNow()), 32'(vecs[i].ctl));
      if (vecs[i].ctl[0])
        checkOutput($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].rpc);
      checkOutput($sformatf("v%0d state", i), 32'(state), 32'(vecs[i].st));
      checkOutput($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(vecs[i].sc));
      checkOutput($sformatf("v%0d flush_count", i), 32'(flush_count), 32'(vecs[i].fc));
      checkOutput($sformatf("v%0d freeze_count", i), 32'(freeze_count), 32'(vecs[i].zc));
    end

    // Saturation: 20 stall cycles on a 4-bit counter, then clear together with a stall.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("sat stall_count", 32'(stall_count), 32'd15);
    checkOutput("sat ctl", 32'(ctlNow()), 32'(C_STALL));
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("clr stall_count", 32'(stall_count), 32'd0);

    // Reset in the middle of a freeze that holds a pending redirect.
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 32'h500, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    checkOutput("pre-reset state", 32'(state), 32'd2);
    #2;
    rst_n = 1'b0;
    stall_req = 1'b1;
    #1;
    checkOutput("in-reset state", 32'(state), 32'd0);
    checkOutput("in-reset ctl", 32'(ctlNow()), 32'(C_IDLE));
    checkOutput("in-reset freeze_count", 32'(freeze_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    checkOutput("post-reset ctl", 32'(ctlNow()), 32'(C_IDLE));
    @(negedge clk);
    #1;
    checkOutput("post-reset ctl2", 32'(ctlNow()), 32'(C_IDLE));
    checkOutput("post-reset state", 32'(state), 32'd0);
    checkOutput("post-reset counters", {20'h0, stall_count, flush_count, freeze_count}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
